set_assoc_cache: RTL and testbench
==================================

// Module: set_assoc_cache
// PURPOSE
//   Parametrised N-way set-associative line cache between the memory stage and the SRAM controller.
//   Zero-cycle combinational lookup (hit/readData); registered fill, true-LRU age update and
//   write-invalidate. Adds a multi-cycle flush sweep with a busy flag.
//   Replaces the fixed 2-way/64-set/2-word array; default parameters reproduce that geometry.
// PARAMETERS
//   ADDR_W  17  word-address width: {tag, index, offset}
//   DATA_W  32  word width
//   WORDS    2  words per line, power of 2 (>=2); OFF_W = log2(WORDS)
//   SETS    64  number of sets, power of 2; IDX_W = log2(SETS)
//   WAYS     2  associativity, power of 2, 2..8; AGE_W = log2(WAYS)
//   TAG_W is derived as ADDR_W-IDX_W-OFF_W (10 at defaults).
// PORTS
//   clk               in   1              rising-edge clock
//   rst               in   1              async active-high reset
//   cache_address     in   ADDR_W         {tag, index, offset}
//   cache_read_en     in   1              lookup access; on hit, updates LRU
//   cache_write_en    in   1              line fill at cache_address's tag/index
//   cache_write_data  in   WORDS*DATA_W   fill line; word k at bits [k*DATA_W +: DATA_W]
//   check_invalid     in   1              store snoop: invalidate the line on hit
//   flush             in   1              one-cycle pulse starts a full invalidate sweep
//   hit               out  1              tag match in a valid way (combinational)
//   readData          out  DATA_W         word [offset] of the hitting way, else 0
//   busy              out  1              flush sweep in progress
// BEHAVIOUR
//   Reset (async): all valid=0, tag=0, busy=0, sweep counter=0, age[set][w]=w. Data contents are
//     unspecified. hit=0, readData=0.
//   Lookup: way w hits iff valid[idx][w] && tag[idx][w]==tag. An invalid way never hits.
//     hit = OR over ways. readData = word[offset] of the lowest-index hitting way; 0 on miss
//     or while busy. hit is forced to 0 while busy.
//   LRU: per-set AGE_W-bit age per way; ages are a permutation of 0..WAYS-1; 0 = MRU.
//     touch(w): every way with age<age[w] increments; age[w] becomes 0.
//     demote(w): every way with age>age[w] decrements; age[w] becomes WAYS-1.
//   Victim (fill, no hit): the lowest-index invalid way; otherwise the way with age==WAYS-1.
//   Per posedge, when not busy, priority is read_en > write_en:
//     read_en with hit: touch(hitting way). A read miss changes no state.
//     write_en with hit: overwrite the hitting way's data, then touch it. No duplicate tags.
//     write_en without hit: write data and tag into the victim, set valid=1, touch(victim).
//     check_invalid with hit (and write_en low): valid=0 and demote(hitting way).
//       When combined with read_en, invalidate wins; the touch is discarded.
//     check_invalid together with write_en: check_invalid is ignored and the fill wins.
//   Flush FSM has two states, IDLE and SWEEP.
//     IDLE->SWEEP on a posedge with flush=1. busy=1 from that edge onward.
//     SWEEP: each cycle, clear all valid bits of set cnt, reset its ages to age[w]=w, then cnt++.
//     After the edge that clears set SETS-1, return to IDLE: busy=0 and cnt=0.
//     busy is high for exactly SETS cycles.
//     In SWEEP, read_en, write_en, check_invalid and flush are ignored.
//     Async reset mid-sweep returns immediately to IDLE (busy=0, all invalid).
//   Index and offset fields are used directly; there is no wrap or arithmetic on the address.
//   Latency: lookup 0 cycles; fill, invalidate and LRU effects are visible the cycle after the edge.
// TESTING (defaults unless noted; A(t,i,o) = t<<7 | i<<1 | o)
//   1 Reset, then read A(0,0,0) -> hit=0, readData=0, busy=0. No spurious hit on tag 0.
//   2 Fill A(1,1,0) with {32'hBBBBBBBB,32'hAAAAAAAA}. Read A(1,1,0) -> hit=1, data AAAAAAAA.
//     Read A(1,1,1) -> BBBBBBBB.
//   3 Fill tags 1 and 2 at index 1, read tag 1, then fill tag 3 -> tag 2 misses, tags 1 and 3 hit.
//   4 check_invalid on A(3,1,0) -> next cycle it misses. Fill tag 4 at index 1 -> it takes the freed
//     way, and tag 1 still hits. Repeat with read_en and check_invalid together -> line is invalid.
//   5 Re-fill A(1,1,0) with new data -> new data read, and the other way's tag is still resident.
//     With WAYS=4: fill 4 tags, touch tags 0..2, fill a 5th -> tag 3 is evicted.
//   6 Fill several sets, pulse flush -> busy=1 for exactly 64 cycles, hit=0 throughout, and reads
//     ignored. All lines miss afterwards. rst at sweep cycle 10 -> busy=0 at once, and all lines miss.

Source files
------------

// File: rtl/set_assoc_cache_if.sv
// Request/response bundle between the memory stage and the line cache.
// The cache side is the slave; the requester drives the master side.
interface set_assoc_cache_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int WORDS  = 2
);
  logic [ADDR_W-1:0]       cache_address;
  logic                    cache_read_en;
  logic                    cache_write_en;
  logic [WORDS*DATA_W-1:0] cache_write_data;
  logic                    check_invalid;
  logic                    flush;
  logic                    hit;
  logic [DATA_W-1:0]       readData;
  logic                    busy;

  modport master (
    output cache_address, cache_read_en, cache_write_en,
    output cache_write_data, check_invalid, flush,
    input  hit, readData, busy
  );

  modport slave (
    input  cache_address, cache_read_en, cache_write_en,
    input  cache_write_data, check_invalid, flush,
    output hit, readData, busy
  );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative line cache: combinational lookup, registered
// fill / true-LRU / snoop invalidate, and a one-set-per-cycle flush sweep.
module set_assoc_cache #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int WORDS  = 2,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  set_assoc_cache_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef logic [AGE_W-1:0] age_t;
  typedef enum logic {IDLE, SWEEP} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy;

  logic                         valid_q [SETS][WAYS];
  logic [TAG_W-1:0]             tag_q   [SETS][WAYS];
  age_t                         age_q   [SETS][WAYS];
  logic [WORDS-1:0][DATA_W-1:0] data_q  [SETS][WAYS];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign off = bus.cache_address[OFF_W-1:0];
  assign idx = bus.cache_address[OFF_W +: IDX_W];
  assign tag = bus.cache_address[ADDR_W-1 -: TAG_W];

  logic hit_any;
  age_t hit_way;
  age_t victim;
  logic do_inv;
  logic do_fill;
  logic do_touch;
  age_t tgt;
  age_t age_d [WAYS];

  // tag compare; the downward scan leaves the lowest hitting way
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = age_t'(w);
      end
    end
  end

  // victim: LRU way, overridden by the lowest invalid way
  always_comb begin
    victim = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (age_q[idx][w] == age_t'(WAYS-1))
        victim = age_t'(w);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[idx][w])
        victim = age_t'(w);
    end
  end

  // operation select: a fill blocks the snoop, a snoop blocks the touch
  always_comb begin
    do_inv   = !busy && bus.check_invalid &&
               !bus.cache_write_en && hit_any;
    do_fill  = !busy && bus.cache_write_en &&
               !bus.cache_read_en;
    do_touch = !busy && !do_inv &&
               ((bus.cache_read_en && hit_any) || do_fill);
    tgt      = (do_fill && !hit_any) ? victim : hit_way;
  end

  // next ages for the addressed set: touch or demote the target way
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      age_d[w] = age_q[idx][w];
      if (do_touch) begin
        if (w == int'(tgt))
          age_d[w] = '0;
        else if (age_q[idx][w] < age_q[idx][tgt])
          age_d[w] = age_q[idx][w] + 1'b1;
      end else if (do_inv) begin
        if (w == int'(tgt))
          age_d[w] = age_t'(WAYS-1);
        else if (age_q[idx][w] > age_q[idx][tgt])
          age_d[w] = age_q[idx][w] - 1'b1;
      end
    end
  end

  // flush FSM next state; the sweep ends on the edge that clears the last set
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush)
          state_d = SWEEP;
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS-1))
          state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == SWEEP);

  // flush FSM state and sweep counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // tag/valid/age arrays: sweep clear, snoop invalidate, fill and LRU update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= age_t'(w);
        end
      end
    end else if (busy) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[cnt_q][w] <= 1'b0;
        age_q[cnt_q][w]   <= age_t'(w);
      end
    end else begin
      if (do_inv)
        valid_q[idx][tgt] <= 1'b0;
      if (do_fill) begin
        valid_q[idx][tgt] <= 1'b1;
        tag_q[idx][tgt]   <= tag;
      end
      if (do_touch || do_inv) begin
        for (int w = 0; w < WAYS; w++)
          age_q[idx][w] <= age_d[w];
      end
    end
  end

  // line data has no reset; only a fill writes it
  always_ff @(posedge clk) begin
    if (do_fill)
      data_q[idx][tgt] <= bus.cache_write_data;
  end

  assign bus.hit      = hit_any && !busy;
  assign bus.readData = bus.hit ? data_q[idx][hit_way][off] : '0;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: a 2-way and a 4-way instance driven from
// step tables; expected lookups go through a scoreboard queue.
module tb_set_assoc_cache;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int WD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_assoc_cache_if #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WD)) b2 ();
  set_assoc_cache_if #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WD)) b4 ();

  set_assoc_cache #(.WAYS(2)) d2 (.clk(clk), .rst(rst), .bus(b2));
  set_assoc_cache #(.WAYS(4)) d4 (.clk(clk), .rst(rst), .bus(b4));

  typedef enum {OP_FILL, OP_READ, OP_LOOK, OP_INV, OP_RDINV} op_e;
  typedef struct {
    op_e         op;
    bit          w4;
    logic [16:0] a;
    logic [63:0] d;
    logic        eh;
    logic [31:0] ed;
  } step_t;
  typedef struct {
    bit          w4;
    logic [32:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [16:0] A(int t, int i, int o);
    return 17'((t << 7) | (i << 1) | o);
  endfunction

  function automatic step_t S(op_e op, bit w4, logic [16:0] a,
                              logic [63:0] d, logic eh, logic [31:0] ed);
    step_t s;
    s.op = op; s.w4 = w4; s.a = a; s.d = d; s.eh = eh; s.ed = ed;
    return s;
  endfunction

  function automatic logic [32:0] out(bit w4);
    return w4 ? {b4.hit, b4.readData} : {b2.hit, b2.readData};
  endfunction

  task automatic clr();
    b2.cache_address = '0; b2.cache_read_en = 0; b2.cache_write_en = 0;
    b2.cache_write_data = '0; b2.check_invalid = 0; b2.flush = 0;
    b4.cache_address = '0; b4.cache_read_en = 0; b4.cache_write_en = 0;
    b4.cache_write_data = '0; b4.check_invalid = 0; b4.flush = 0;
  endtask

  task automatic drv(bit w4, logic re, logic we, logic ci,
                     logic [16:0] a, logic [63:0] d);
    clr();
    if (w4) begin
      b4.cache_address = a; b4.cache_read_en = re;
      b4.cache_write_en = we; b4.check_invalid = ci;
      b4.cache_write_data = d;
    end else begin
      b2.cache_address = a; b2.cache_read_en = re;
      b2.cache_write_en = we; b2.check_invalid = ci;
      b2.cache_write_data = d;
    end
  endtask

  // drive one step; lookups queue their expected {hit, data}
  task automatic apply(step_t s, string nm);
    exp_t e;
    case (s.op)
      OP_FILL:  drv(s.w4, 0, 1, 0, s.a, s.d);
      OP_READ:  drv(s.w4, 1, 0, 0, s.a, '0);
      OP_LOOK:  drv(s.w4, 0, 0, 0, s.a, '0);
      OP_INV:   drv(s.w4, 0, 0, 1, s.a, '0);
      OP_RDINV: drv(s.w4, 1, 0, 1, s.a, '0);
      default:  clr();
    endcase
    if (s.op == OP_READ || s.op == OP_LOOK || s.op == OP_RDINV) begin
      e.w4 = s.w4; e.v = {s.eh, s.ed}; e.nm = nm;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t e;
    logic [32:0] got;
    clr();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (b2.busy !== 1'b0 || b4.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b/%b want 0/0", b2.busy, b4.busy);
    end
    st.push_back(S(OP_READ, 0, A(0, 0, 0), '0, 0, 32'h0));
    st.push_back(S(OP_LOOK, 0, A(0, 63, 1), '0, 0, 32'h0));
    st.push_back(S(OP_READ, 1, A(0, 2, 0), '0, 0, 32'h0));
    foreach (st[k]) begin
      @(negedge clk);
      apply(st[k], $sformatf("reset.%0d", k));
      if (sb.size() != 0) begin
        #1 e = sb.pop_front();
        got = out(e.w4);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
        end
      end
    end
    @(negedge clk) clr();
  endtask

  task automatic test_fill();
    step_t st[$];
    exp_t e;
    logic [32:0] got;
    st.push_back(S(OP_FILL, 0, A(1, 1, 0),
                   {32'hBBBBBBBB, 32'hAAAAAAAA}, 0, 0));
    st.push_back(S(OP_READ, 0, A(1, 1, 0), '0, 1, 32'hAAAAAAAA));
    st.push_back(S(OP_READ, 0, A(1, 1, 1), '0, 1, 32'hBBBBBBBB));
    st.push_back(S(OP_LOOK, 0, A(1, 2, 0), '0, 0, 32'h0));
    foreach (st[k]) begin
      @(negedge clk);
      apply(st[k], $sformatf("fill.%0d", k));
      if (sb.size() != 0) begin
        #1 e = sb.pop_front();
        got = out(e.w4);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
        end
      end
    end
    @(negedge clk) clr();
  endtask

  task automatic test_lru_evict();
    step_t st[$];
    exp_t e;
    logic [32:0] got;
    st.push_back(S(OP_FILL, 0, A(2, 1, 0),
                   {32'h22220001, 32'h22220000}, 0, 0));
    st.push_back(S(OP_READ, 0, A(1, 1, 0), '0, 1, 32'hAAAAAAAA));
    st.push_back(S(OP_FILL, 0, A(3, 1, 0),
                   {32'h33330001, 32'h33330000}, 0, 0));
    st.push_back(S(OP_LOOK, 0, A(2, 1, 0), '0, 0, 32'h0));
    st.push_back(S(OP_LOOK, 0, A(1, 1, 0), '0, 1, 32'hAAAAAAAA));
    st.push_back(S(OP_LOOK, 0, A(3, 1, 0), '0, 1, 32'h33330000));
    foreach (st[k]) begin
      @(negedge clk);
      apply(st[k], $sformatf("evict.%0d", k));
      if (sb.size() != 0) begin
        #1 e = sb.pop_front();
        got = out(e.w4);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
        end
      end
    end
    @(negedge clk) clr();
  endtask

  task automatic test_invalidate();
    step_t st[$];
    exp_t e;
    logic [32:0] got;
    st.push_back(S(OP_INV,  0, A(3, 1, 0), '0, 0, 0));
    st.push_back(S(OP_LOOK, 0, A(3, 1, 0), '0, 0, 32'h0));
    st.push_back(S(OP_FILL, 0, A(4, 1, 0),
                   {32'h44440001, 32'h44440000}, 0, 0));
    st.push_back(S(OP_LOOK, 0, A(4, 1, 1), '0, 1, 32'h44440001));
    st.push_back(S(OP_LOOK, 0, A(1, 1, 0), '0, 1, 32'hAAAAAAAA));
    st.push_back(S(OP_RDINV, 0, A(4, 1, 0), '0, 1, 32'h44440000));
    st.push_back(S(OP_LOOK, 0, A(4, 1, 0), '0, 0, 32'h0));
    st.push_back(S(OP_LOOK, 0, A(1, 1, 1), '0, 1, 32'hBBBBBBBB));
    foreach (st[k]) begin
      @(negedge clk);
      apply(st[k], $sformatf("inval.%0d", k));
      if (sb.size() != 0) begin
        #1 e = sb.pop_front();
        got = out(e.w4);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
        end
      end
    end
    @(negedge clk) clr();
  endtask

  task automatic test_refill_lru4();
    step_t st[$];
    exp_t e;
    logic [32:0] got;
    st.push_back(S(OP_FILL, 0, A(5, 1, 0),
                   {32'h55550001, 32'h55550000}, 0, 0));
    st.push_back(S(OP_FILL, 0, A(1, 1, 0),
                   {32'hDDDDDDDD, 32'hCCCCCCCC}, 0, 0));
    st.push_back(S(OP_READ, 0, A(1, 1, 0), '0, 1, 32'hCCCCCCCC));
    st.push_back(S(OP_READ, 0, A(1, 1, 1), '0, 1, 32'hDDDDDDDD));
    st.push_back(S(OP_LOOK, 0, A(5, 1, 0), '0, 1, 32'h55550000));
    for (int t = 10; t < 14; t++)
      st.push_back(S(OP_FILL, 1, A(t, 2, 0),
                     {32'hE0000000 + 32'(t), 32'hF0000000 + 32'(t)}, 0, 0));
    for (int t = 10; t < 13; t++)
      st.push_back(S(OP_READ, 1, A(t, 2, 0), '0, 1,
                     32'hF0000000 + 32'(t)));
    st.push_back(S(OP_FILL, 1, A(14, 2, 0),
                   {32'hE000000E, 32'hF000000E}, 0, 0));
    st.push_back(S(OP_LOOK, 1, A(13, 2, 0), '0, 0, 32'h0));
    for (int t = 10; t < 13; t++)
      st.push_back(S(OP_LOOK, 1, A(t, 2, 1), '0, 1,
                     32'hE0000000 + 32'(t)));
    st.push_back(S(OP_LOOK, 1, A(14, 2, 0), '0, 1, 32'hF000000E));
    foreach (st[k]) begin
      @(negedge clk);
      apply(st[k], $sformatf("lru.%0d", k));
      if (sb.size() != 0) begin
        #1 e = sb.pop_front();
        got = out(e.w4);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
        end
      end
    end
    @(negedge clk) clr();
  endtask

  task automatic test_flush();
    step_t st[$];
    exp_t e;
    logic [32:0] got;
    int n;
    st.push_back(S(OP_FILL, 0, A(7, 5, 0), {32'h7, 32'h70}, 0, 0));
    st.push_back(S(OP_FILL, 0, A(8, 9, 0), {32'h8, 32'h80}, 0, 0));
    st.push_back(S(OP_FILL, 0, A(9, 63, 1), {32'h9, 32'h90}, 0, 0));
    st.push_back(S(OP_LOOK, 0, A(9, 63, 1), '0, 1, 32'h9));
    foreach (st[k]) begin
      @(negedge clk);
      apply(st[k], $sformatf("flush_pre.%0d", k));
      if (sb.size() != 0) begin
        #1 e = sb.pop_front();
        got = out(e.w4);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
        end
      end
    end
    @(negedge clk);
    clr();
    b2.flush = 1'b1;
    @(negedge clk);
    b2.flush = 1'b0;
    n = 0;
    while (b2.busy === 1'b1 && n < 200) begin
      if (n[0])
        apply(S(OP_FILL, 0, A(20, 3, 0), {32'h2, 32'h20}, 0, 0), "");
      else
        apply(S(OP_READ, 0, A(7, 5, 0), '0, 0, 0), "");
      e.w4 = 0; e.v = '0; e.nm = $sformatf("sweep_quiet.%0d", n);
      sb.push_back(e);
      #1 e = sb.pop_front();
      while (sb.size() != 0) e = sb.pop_front();
      got = out(0);
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
      end
      n++;
      @(negedge clk);
    end
    clr();
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL busy_cycles got %0d want 64", n);
    end
    st.delete();
    st.push_back(S(OP_LOOK, 0, A(7, 5, 0), '0, 0, 32'h0));
    st.push_back(S(OP_LOOK, 0, A(8, 9, 0), '0, 0, 32'h0));
    st.push_back(S(OP_LOOK, 0, A(9, 63, 1), '0, 0, 32'h0));
    st.push_back(S(OP_LOOK, 0, A(1, 1, 0), '0, 0, 32'h0));
    st.push_back(S(OP_LOOK, 0, A(20, 3, 0), '0, 0, 32'h0));
    st.push_back(S(OP_FILL, 0, A(7, 40, 0), {32'h71, 32'h70}, 0, 0));
    st.push_back(S(OP_LOOK, 0, A(7, 40, 0), '0, 1, 32'h70));
    foreach (st[k]) begin
      @(negedge clk);
      apply(st[k], $sformatf("flush_post.%0d", k));
      if (sb.size() != 0) begin
        #1 e = sb.pop_front();
        got = out(e.w4);
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
        end
      end
    end
    @(negedge clk);
    clr();
    b2.flush = 1'b1;
    @(negedge clk);
    b2.flush = 1'b0;
    repeat (10) @(negedge clk);
    b2.cache_address = A(7, 40, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (b2.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_sweep_busy got %b want 0", b2.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(S(OP_LOOK, 0, A(7, 40, 0), '0, 0, 32'h0), "rst_sweep_miss");
    #1 e = sb.pop_front();
    got = out(e.w4);
    checks++;
    if (got !== e.v) begin
      errors++;
      $display("FAIL %s got hit/data %h want %h", e.nm, got, e.v);
    end
    @(negedge clk) clr();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lru_evict();
    test_invalidate();
    test_refill_lru4();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
